// File: rtl/fetch_unit_if.sv
// fetch_unit_if: control, ROM read port and instruction handshake of the fetch stage
interface fetch_unit_if #(
  parameter int ADDR_W = 5,
  parameter int INST_W = 10
);
  logic start;
  logic halt;
  logic jump;
  logic [ADDR_W-1:0] jump_addr;
  logic [ADDR_W-1:0] a_rom;
  logic [INST_W-1:0] rom_q;
  logic rom_rd;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic inst_valid;
  logic inst_ready;
  logic running;
  modport master (
    input start, halt, jump, jump_addr, rom_q, inst_ready,
    output a_rom, rom_rd, inst, inst_pc, inst_valid, running
  );
  modport slave (
    output start, halt, jump, jump_addr, rom_q, inst_ready,
    input a_rom, rom_rd, inst, inst_pc, inst_valid, running
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, ROM read sequencing and prefetch FIFO feeding the control unit
module fetch_unit #(
  parameter int ADDR_W = 5,
  parameter int INST_W = 10,
  parameter int DEPTH = 2
) (
  input logic clock,
  input logic reset,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt, inflight_pc;
  logic inflight;
  logic [CW-1:0] count, count_nxt, wr_idx;
  logic [CW:0] occ;
  logic [ADDR_W-1:0] mem_pc [DEPTH];
  logic [ADDR_W-1:0] mem_pc_nxt [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [INST_W-1:0] mem_inst_nxt [DEPTH];
  logic run, valid, flush, start_ok, accept, push, rd;
  assign run = state == RUN;
  assign valid = count != '0;
  assign flush = run && (bus.halt || bus.jump);
  assign start_ok = bus.start && !run && !bus.halt;
  assign accept = valid && bus.inst_ready;
  // occupancy counts the read already on its way so the FIFO can never overflow
  assign occ = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(accept);
  assign rd = run && !bus.halt && !bus.jump && occ < (CW+1)'(DEPTH);
  assign push = inflight && run && !flush;
  assign wr_idx = count - CW'(accept);
  assign bus.a_rom = fetch_pc;
  assign bus.rom_rd = rd;
  assign bus.inst = mem_inst[0];
  assign bus.inst_pc = mem_pc[0];
  assign bus.inst_valid = valid;
  assign bus.running = run;
  always_comb begin
    state_nxt = (run && bus.halt) ? HALTED : start_ok ? RUN : state;
    fetch_pc_nxt = (run && bus.halt) ? fetch_pc :
                   (run && bus.jump) ? bus.jump_addr :
                   start_ok ? '0 :
                   rd ? fetch_pc + 1'b1 : fetch_pc;
    count_nxt = flush ? '0 : count - CW'(accept) + CW'(push);
    mem_pc_nxt = mem_pc;
    mem_inst_nxt = mem_inst;
    // the head only shifts when a successor exists, so an emptied FIFO keeps showing its last word
    if (!flush && accept && count > CW'(1))
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_pc_nxt[i] = mem_pc[i+1];
        mem_inst_nxt[i] = mem_inst[i+1];
      end
    if (push)
      for (int i = 0; i < DEPTH; i++)
        if (CW'(i) == wr_idx) begin
          mem_pc_nxt[i] = inflight_pc;
          mem_inst_nxt[i] = bus.rom_q;
        end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      fetch_pc <= '0;
      inflight <= 1'b0;
      inflight_pc <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i] <= '0;
        mem_inst[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      inflight <= rd;
      inflight_pc <= fetch_pc;
      count <= count_nxt;
      mem_pc <= mem_pc_nxt;
      mem_inst <= mem_inst_nxt;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus reset and start-latency sequences for fetch_unit
module tb_fetch_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [9:0] rom [32];
  int total = 0;
  int bad = 0;
  typedef struct {
    logic st, ht, jp;
    logic [4:0] ja;
    logic rdy, v;
    logic [4:0] pc;
    logic [9:0] ins;
    logic rd;
    logic [4:0] ar;
    logic run;
  } vec_t;
  vec_t vq[$];
  fetch_unit_if #(.ADDR_W(5), .INST_W(10)) bus ();
  fetch_unit dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  always @(posedge clock) if (bus.rom_rd) bus.rom_q <= rom[bus.a_rom];
  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic void add(logic st, logic ht, logic jp, logic [4:0] ja, logic rdy,
                              logic v, logic [4:0] pc, logic [9:0] ins, logic rd,
                              logic [4:0] ar, logic run);
    vec_t t;
    t = '{st, ht, jp, ja, rdy, v, pc, ins, rd, ar, run};
    vq.push_back(t);
  endfunction
  task automatic chk_all(string tag, int v, int pc, int ins, int rd, int ar, int run);
    chk({tag, " inst_valid"}, int'(bus.inst_valid), v);
    chk({tag, " inst_pc"}, int'(bus.inst_pc), pc);
    chk({tag, " inst"}, int'(bus.inst), ins);
    chk({tag, " rom_rd"}, int'(bus.rom_rd), rd);
    chk({tag, " a_rom"}, int'(bus.a_rom), ar);
    chk({tag, " running"}, int'(bus.running), run);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    for (int i = 0; i < 32; i++) rom[i] = 10'(i * 3);
    bus.start = 0; bus.halt = 0; bus.jump = 0; bus.jump_addr = 0; bus.inst_ready = 0;
    // st ht jp ja rdy | valid pc inst rd a_rom running
    add(1,0,0, 0,1, 0, 0, 0,0, 0,0);
    add(0,0,0, 0,1, 0, 0, 0,1, 0,1);
    add(0,0,0, 0,1, 0, 0, 0,1, 1,1);
    add(0,0,0, 0,1, 1, 0, 0,1, 2,1);
    add(0,0,0, 0,1, 1, 1, 3,1, 3,1);
    add(0,0,0, 0,1, 1, 2, 6,1, 4,1);
    add(1,0,0, 0,1, 1, 3, 9,1, 5,1);
    add(0,0,1,20,1, 1, 4,12,0, 6,1);
    add(0,0,0, 0,1, 0, 4,12,1,20,1);
    add(0,0,0, 0,1, 0, 4,12,1,21,1);
    add(0,0,0, 0,1, 1,20,60,1,22,1);
    add(0,0,0, 0,1, 1,21,63,1,23,1);
    add(0,0,0, 0,0, 1,22,66,0,24,1);
    for (int i = 0; i < 5; i++) add(0,0,0, 0,0, 1,22,66,0,24,1);
    add(0,0,0, 0,1, 1,22,66,1,24,1);
    add(0,0,0, 0,1, 1,23,69,1,25,1);
    add(0,0,0, 0,1, 1,24,72,1,26,1);
    add(0,0,1,30,1, 1,25,75,0,27,1);
    add(0,0,0, 0,1, 0,25,75,1,30,1);
    add(0,0,0, 0,1, 0,25,75,1,31,1);
    add(0,0,0, 0,1, 1,30,90,1, 0,1);
    add(0,0,0, 0,1, 1,31,93,1, 1,1);
    add(0,0,0, 0,1, 1, 0, 0,1, 2,1);
    add(0,0,0, 0,1, 1, 1, 3,1, 3,1);
    add(0,0,0, 0,0, 1, 2, 6,0, 4,1);
    add(0,0,0, 0,0, 1, 2, 6,0, 4,1);
    add(0,1,1,10,0, 1, 2, 6,0, 4,1);
    add(0,0,0, 0,1, 0, 2, 6,0, 4,0);
    add(0,0,1, 9,1, 0, 2, 6,0, 4,0);
    add(0,0,0, 0,1, 0, 2, 6,0, 4,0);
    add(1,0,0, 0,0, 0, 2, 6,0, 4,0);
    add(0,0,0, 0,0, 0, 2, 6,1, 0,1);
    add(0,0,0, 0,0, 0, 2, 6,1, 1,1);
    for (int i = 0; i < 3; i++) add(0,0,0, 0,0, 1, 0, 0,0, 2,1);
    add(0,0,0, 0,1, 1, 0, 0,1, 2,1);
    add(0,0,0, 0,1, 1, 1, 3,1, 3,1);
    add(0,0,0, 0,1, 1, 2, 6,1, 4,1);
    add(0,0,0, 0,1, 1, 3, 9,1, 5,1);
    #3;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    foreach (vq[i]) begin
      @(negedge clock);
      bus.start = vq[i].st;
      bus.halt = vq[i].ht;
      bus.jump = vq[i].jp;
      bus.jump_addr = vq[i].ja;
      bus.inst_ready = vq[i].rdy;
      #1;
      chk_all($sformatf("row%0d", i), vq[i].v, vq[i].pc, vq[i].ins, vq[i].rd, vq[i].ar, vq[i].run);
    end
    @(negedge clock);
    bus.start = 0; bus.halt = 0; bus.jump = 0; bus.inst_ready = 1;
    #2 reset = 1'b0;
    #1 chk_all("async reset", 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1 chk_all("after reset", 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    bus.start = 1;
    @(posedge clock);
    #1 bus.start = 0;
    n = 0;
    while (!bus.inst_valid && n < 8) begin
      @(posedge clock);
      #1 n++;
    end
    chk("start latency", n, 2);
    chk("first inst_pc", int'(bus.inst_pc), 0);
    chk("first inst", int'(bus.inst), 0);
    @(posedge clock);
    #1 chk("second inst_pc", int'(bus.inst_pc), 1);
    chk("second inst", int'(bus.inst), 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
